// File: rtl/stat_resp_misr.sv
// Response compactor: folds a stream of netlist response vectors into a MISR
// signature and compares the final signature against a golden value.
module stat_resp_misr #(
  parameter int unsigned       DATA_W = 24,
  parameter int unsigned       CNT_W  = 16,
  parameter logic [DATA_W-1:0] POLY   = 24'h00001B,
  parameter logic [DATA_W-1:0] SEED   = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [DATA_W-1:0] golden,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] signature,
  output logic [CNT_W-1:0]  pattern_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [DATA_W-1:0]  golden_q, golden_d;
  logic               pass_q, pass_d;
  logic [DATA_W-1:0]  misr_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               accept_c;

  // Abort blocks acceptance so an aborted run never absorbs a final beat
  assign resp_ready    = (state_q == RUN) && !abort;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign signature     = sig_q;
  assign pattern_count = cnt_q;

  assign accept_c  = resp_valid && resp_ready;
  assign misr_c    = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? POLY : '0) ^ resp_data;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      golden_q <= golden_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    golden_d = golden_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_d    = SEED;
          cnt_d    = '0;
          num_d    = num_patterns;
          golden_d = golden;
          if (num_patterns == '0) begin
            state_d = DONE;
            pass_d  = (SEED == golden);
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (accept_c) begin
          sig_d = misr_c;
          cnt_d = cnt_inc_c;
          // Final beat: verdict uses the post-update signature
          if (cnt_inc_c == num_q) begin
            state_d = DONE;
            pass_d  = (misr_c == golden_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
